// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and its neighbours.
// Holds the fetch FSM state encoding, the machine word width and the default reset PC.
// Also provides a small alignment helper so every user checks PCs the same way.
package cpu_pkg;

  // Machine word width; instruction words, addresses and PCs are all this wide.
  localparam int WORD_W = 32;

  // Default PC loaded on reset; must be word aligned.
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch FSM states:
  //   FETCH - request outstanding to instruction memory
  //   HOLD  - instruction held and presented to the core
  //   FAULT - misaligned next PC seen; only reset leaves this state
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // A PC is usable only when it points at a whole word.
  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_req_ctrl.sv
// Fetch FSM and handshake control: sequences FETCH -> HOLD -> FETCH/FAULT.
// Latency: imem_req/instr_valid are registered; an ack completes a fetch in the same cycle.
// Backpressure: holds in FETCH until imem_ack and in HOLD until instr_ready.
module fetch_req_ctrl
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  // instruction memory handshake
  input  logic imem_ack,
  output logic imem_req,
  // core handshake
  input  logic instr_ready,
  output logic instr_valid,
  // next PC from the core is word aligned
  input  logic pc_nxt_aligned,
  // datapath strobes for the top-level registers
  output logic fetch_done,
  output logic accept_ok,
  output logic accept_bad
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         req_q;
  logic         req_d;
  logic         valid_q;
  logic         valid_d;

  // Handshake strobes. An ack only counts while the request is actually
  // visible on the bus; the cycle straight after reset has state FETCH but
  // req still low, and the memory has nothing in flight then.
  always_comb begin
    fetch_done = 1'b0;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    if ((state_q == FETCH) && req_q && imem_ack) begin
      fetch_done = 1'b1;
    end
    if ((state_q == HOLD) && instr_ready) begin
      accept_ok  = pc_nxt_aligned;
      accept_bad = ~pc_nxt_aligned;
    end
  end

  // Next-state logic plus the next value of the registered outputs, which
  // are decoded from the state being entered so they line up with it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (fetch_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept_ok) begin
          state_d = FETCH;
        end else if (accept_bad) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        // Unused encoding: restart fetching from the current PC.
        state_d = FETCH;
      end
    endcase
    req_d   = (state_d == FETCH);
    valid_d = (state_d == HOLD);
  end

  // State and registered handshake outputs; reset wins over everything and
  // drops any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign instr_valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words and presents them to the execute core.
// Latency: one cycle from req to instruction held when memory acks at once; 2 cycles per instruction.
// Backpressure: memory stalls hold req/addr stable; core stalls hold instr/pc stable in HOLD.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction memory
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  // execute core
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [31:0]       pc_nxt,
  // status
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [CNT_W-1:0]  retired_count
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] instr_d;
  logic              fault_q;
  logic              fault_d;
  logic [WORD_W-1:0] fault_pc_q;
  logic [WORD_W-1:0] fault_pc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              pc_nxt_aligned;
  logic              fetch_done;
  logic              accept_ok;
  logic              accept_bad;

  // pc_nxt only matters on the accepting edge; the FSM qualifies it.
  assign pc_nxt_aligned = is_word_aligned(pc_nxt);

  fetch_req_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .imem_ack       (imem_ack),
    .imem_req       (imem_req),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .pc_nxt_aligned (pc_nxt_aligned),
    .fetch_done     (fetch_done),
    .accept_ok      (accept_ok),
    .accept_bad     (accept_bad)
  );

  // Datapath next values. A misaligned next PC is still a retired
  // instruction: the core consumed it, only the redirect is rejected, so
  // pc keeps the last good value and the bad target is captured separately.
  // The counter wraps naturally at its width.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;
    if (fetch_done) begin
      instr_d = imem_rdata;
    end
    if (accept_ok) begin
      pc_d = pc_nxt;
    end
    if (accept_bad) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_nxt;
    end
    if (accept_ok || accept_bad) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Architectural PC, held instruction, sticky fault and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // The address bus is the PC register itself, so it cannot move while a
  // request is outstanding.
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign fault         = fault_q;
  assign fault_pc      = fault_pc_q;
  assign retired_count = cnt_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential instruction-fetch stage sitting directly upstream of the single-cycle combinational execute core.
- Owns the architectural PC register and issues word reads to instruction memory over a req/ack handshake.
- Holds the fetched instruction and its PC stable for the core under a valid/ready handshake.
- When the core accepts an instruction, loads the core's computed next PC and starts the next fetch. Flags misaligned PCs.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk input 1: the single clock; all state updates on its rising edge.
- rst input 1: synchronous, active-high reset.
- imem_req output 1: instruction read request.
- imem_addr output 32: read address, always equal to the PC register.
- imem_ack input 1: read complete; imem_rdata is valid in the same cycle.
- imem_rdata input 32: instruction word.
- instr output 32: held instruction, drives the core's instr input.
- pc output 32: PC of the held instruction, drives the core's pc input.
- instr_valid output 1: instr/pc are valid for the core.
- instr_ready input 1: core consumes instr this cycle; pc_nxt is valid.
- pc_nxt input 32: next PC computed by the core.
- fault output 1: sticky misaligned-PC fault.
- fault_pc output 32: offending misaligned PC.
- retired_count output CNT_W: number of accepted instructions.

Behaviour:
- Only clk and rst are used for timing. Reset is sampled only on the rising edge of clk.
- States are FETCH, HOLD and FAULT, encoded as a 2-bit enum.
- Reset values:
  - state = FETCH, pc = RESET_PC, instr = 0.
  - instr_valid = 0, fault = 0, fault_pc = 0, retired_count = 0.
  - imem_req is registered and is 0 in the reset cycle.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - Both are held stable until an ack.
  - On imem_ack: instr <= imem_rdata, go to HOLD.
  - Ack may arrive in the first cycle req is high, so minimum fetch latency is 1 cycle from req assertion.
- HOLD:
  - instr_valid = 1 and imem_req = 0; instr and pc are stable.
  - While instr_ready = 0, stay in HOLD.
  - When instr_ready = 1:
    - retired_count increments, wrapping modulo 2^CNT_W.
    - If pc_nxt[1:0] == 0: pc <= pc_nxt, go to FETCH.
    - Otherwise: fault <= 1, fault_pc <= pc_nxt, go to FAULT.
- FAULT:
  - imem_req = 0 and instr_valid = 0; fault is held at 1.
  - The state is left only by rst.
  - pc still holds the last good PC.
- Steady-state throughput is one instruction per 2 cycles: one FETCH cycle with same-cycle ack, then one HOLD cycle with instr_ready = 1.
- Ignored inputs:
  - imem_ack outside FETCH has no effect.
  - instr_ready outside HOLD has no effect.
- pc_nxt is sampled only on the accepting edge.
- Reset has priority over everything.
  - rst during an outstanding FETCH abandons the request; the next fetch is to RESET_PC.
  - The instruction memory shares rst and drops any in-flight read, so no stale ack can follow.
- PC wrap-around: pc_nxt = 32'hFFFF_FFFC followed by the core's +4 is accepted as 0 and is not a fault.
- imem_addr is combinational from the pc register, so it is stable throughout FETCH.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t (FETCH, HOLD, FAULT).
  - WORD_W = 32.
  - The default RESET_PC constant.
- A single sub-module is natural: fetch_req_ctrl.
  - It contains the FSM and handshake logic.
  - The top level keeps the pc, instr, fault and counter registers.

Test Plan:
- Reset, then imem_ack in the first req cycle with rdata = 32'h2008_0005, instr_ready = 1 in HOLD with pc_nxt = 4 -> imem_addr = 0 then 4; instr = 32'h2008_0005; retired_count = 1; 1 instr per 2 cycles.
- Memory wait of 3 cycles before ack -> imem_req held high 4 cycles with imem_addr constant; instr_valid rises the cycle after ack.
- Core stalls with instr_ready = 0 for 5 cycles in HOLD -> instr and pc unchanged, no new imem_req, retired_count unchanged.
- Branch redirect: accept with pc_nxt = 32'h0000_0040 -> next imem_addr = 0x40.
- Accept with pc_nxt = 32'h0000_0042 -> fault = 1, fault_pc = 0x42, no further imem_req. Then assert rst -> fault = 0, fetch restarts at RESET_PC.
- rst asserted mid-FETCH at pc = 0x100 -> next cycle pc = RESET_PC with imem_req = 0; fetch then resumes at RESET_PC.
